i2c_cmd_sequencer: RTL and testbench
====================================

# i2c_cmd_sequencer

Avalon-MM master that sits directly upstream of the team's Avalon I2C byte engine (`i2c_interface`). It accepts one register-level command per handshake: 7-bit device address, 8-bit register address, write data, and a read/write flag. It expands each command into the engine's primitive operations (START, byte write, ACK status read, byte read, STOP) and returns one response per command: read data plus NACK status. Typical users are a configuration ROM walker or a CPU-side command FIFO.

## Interface
- ABORT_ON_NACK, 1, 1: on NACK, skip the remaining bytes and go straight to STOP; 0: complete the sequence and report the NACK anyway.
- clk  in  1  system clock; the downstream engine uses the same clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer idle, can accept a command.
- cmd_rw  in  1  0 = register write, 1 = register read.
- cmd_dev  in  7  7-bit device address.
- cmd_reg  in  8  register address.
- cmd_wdata  in  8  write data; ignored for reads.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  8  read byte; 0 for writes and for aborted reads.
- rsp_nack  out  1  any ACK phase returned NACK.
- rsp_nack_stage  out  2  first NACK location: 0 = none, 1 = device address, 2 = register address, 3 = data byte or read-phase device address.
- av_address  out  2  engine address.
- av_write  out  1  engine write request.
- av_read  out  1  engine read request.
- av_writedata  out  32  engine write data; bits 31:8 are always 0.
- av_readdata  in  32  engine read data.
- av_readdatavalid  in  1  engine read data valid.
- av_waitrequest  in  1  engine busy.

## Operation
Engine primitives:
- START: write to address 0, data 1.
- STOP: write to address 0, data 0.
- WRBYTE(b): write to address 1, data b.
- ACKRD: read address 0. The result is `av_readdata[1]`; 1 = NACK.
- RDNACK: read address 3. The byte is `av_readdata[7:0]`.

Request rules:
- A request is held until the cycle in which `av_waitrequest` = 0; that cycle is the acceptance.
- `av_write`/`av_read` deassert the cycle after acceptance.
- At most one of `av_write`/`av_read` is high at a time.
- ACKRD and RDNACK then wait for `av_readdatavalid`. No new request is issued while a read is outstanding.

Command acceptance:
- Accepted when `cmd_valid` & `cmd_ready`.
- The command fields are latched on acceptance; `cmd_ready` drops the next cycle.

Write command sequence: START, WRBYTE({dev,0}), ACKRD, WRBYTE(reg), ACKRD, WRBYTE(wdata), ACKRD, STOP, WAIT_IDLE, RESP.

Read command sequence: START, WRBYTE({dev,0}), ACKRD, WRBYTE(reg), ACKRD, START (repeated start), WRBYTE({dev,1}), ACKRD, RDNACK, STOP, WAIT_IDLE, RESP.

NACK handling:
- A NACK sets `rsp_nack` and records `rsp_nack_stage`. Only the first NACK is recorded.
- With ABORT_ON_NACK = 1, the next state is STOP.
- With ABORT_ON_NACK = 0, the sequence continues. A read still returns the byte sampled.

End of sequence:
- WAIT_IDLE: one cycle after STOP acceptance, wait until `av_waitrequest` = 0 (engine idle, STOP complete on the wire).
- RESP: `rsp_valid` = 1 for one cycle, then IDLE with `cmd_ready` = 1.
- There is no response back-pressure; the consumer must sample on the pulse.

Reset:
- Outputs: `cmd_ready` = 0 during reset and 1 from the first cycle after release; `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_nack` = 0, `rsp_nack_stage` = 0; `av_write` = 0, `av_read` = 0, `av_address` = 0, `av_writedata` = 0. FSM = IDLE.
- Reset mid-command drops the command without a response. Bus recovery is left to the next command's START; the engine handles START from any SCL/SDA level.

## Timing
- Acceptance-to-first-request latency: 1 cycle. START is asserted the cycle after command acceptance.
- Inter-request gap: 1 cycle minimum after a write acceptance. After a read, the next request comes 1 cycle after `av_readdatavalid`.
- `rsp_rdata` and `rsp_nack`:
  - Registered.
  - Stable from the `rsp_valid` cycle until the next command acceptance.
  - Cleared to 0 on command acceptance.
- `cmd_ready` and `rsp_valid` are never high in the same cycle. `cmd_ready` rises the cycle after `rsp_valid`.
- A `cmd_valid` asserted while busy is ignored, not queued.
- An `av_readdatavalid` outside an outstanding read is ignored.
- Total latency is dominated by the engine: about 29 I2C bit slots for a write and 39 for a read, each bit slot being 4 `i2c_pclk` ticks.

## Test plan
- Register write, all ACKs: dev=0x1A, reg=0x05, wdata=0xC3 -> engine writes 0x01, 0x34, 0x05, 0xC3, 0x00 in order, each followed by an ACKRD except the START and STOP writes; then `rsp_valid`, `rsp_nack`=0, `rsp_rdata`=0x00.
- Register read: dev=0x50, reg=0x10, slave returns 0x5A -> second START; WRBYTE 0xA1; RDNACK; `rsp_rdata`=0x5A, `rsp_nack`=0, `rsp_nack_stage`=0.
- Device NACK, ABORT_ON_NACK=1: no slave at 0x22 -> after the first ACKRD the next request is STOP; `rsp_nack`=1, `rsp_nack_stage`=1, `rsp_rdata`=0.
- Data NACK, ABORT_ON_NACK=0: slave NACKs only the data byte -> full sequence through STOP; `rsp_nack_stage`=3.
- Handshake stress: engine model holds `av_waitrequest` high for 0–20 random cycles and delays `av_readdatavalid` by 1–5 cycles -> request signals held stable until accepted; no overlapping requests; identical responses; `cmd_valid` during busy is ignored.
- Reset mid-read, asserted during RDNACK -> all outputs at reset values immediately; no `rsp_valid`. The next command (write 0x1A/0x05/0xC3) completes normally.

Source files
------------

// File: rtl/i2c_cmd_sequencer_if.sv
// Command/response handshake plus Avalon-MM engine bus for i2c_cmd_sequencer.
// master: the sequencer's view; slave: the command source / engine side.
interface i2c_cmd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [6:0]  cmd_dev;
    logic [7:0]  cmd_reg;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_nack;
    logic [1:0]  rsp_nack_stage;
    logic [1:0]  av_address;
    logic        av_write;
    logic        av_read;
    logic [31:0] av_writedata;
    logic [31:0] av_readdata;
    logic        av_readdatavalid;
    logic        av_waitrequest;

    modport master (
        input  cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata,
        input  av_readdata, av_readdatavalid, av_waitrequest,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_nack_stage,
        output av_address, av_write, av_read, av_writedata
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata,
        output av_readdata, av_readdatavalid, av_waitrequest,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_nack_stage,
        input  av_address, av_write, av_read, av_writedata
    );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// Expands register-level I2C read/write commands into i2c_interface engine
// primitives (START, byte write, ACK read, byte read, STOP) and reports one response.
module i2c_cmd_sequencer #(
    parameter bit ABORT_ON_NACK = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    i2c_cmd_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_START, ST_DEVW, ST_ACK_DEV, ST_REG, ST_ACK_REG,
        ST_DATA, ST_ACK_DATA, ST_RSTART, ST_DEVR, ST_ACK_DEVR,
        ST_RDBYTE, ST_STOP, ST_WAIT_IDLE, ST_RESP
    } state_t;

    // Each primitive step is issued (REQ), then either idles one cycle (GAP) or awaits read data.
    typedef enum logic [1:0] {PH_REQ, PH_GAP, PH_RDWAIT} phase_t;

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic        rw_q, rw_d;
    logic [6:0]  dev_q, dev_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        nack_q, nack_d;
    logic [1:0]  stage_q, stage_d;

    logic        req_write, req_read;
    logic [1:0]  req_addr;
    logic [7:0]  req_byte;
    logic        unused_rd_hi;

    function automatic state_t step_after(input state_t s, input logic rw);
        case (s)
            ST_START:    return ST_DEVW;
            ST_DEVW:     return ST_ACK_DEV;
            ST_ACK_DEV:  return ST_REG;
            ST_REG:      return ST_ACK_REG;
            ST_ACK_REG:  return rw ? ST_RSTART : ST_DATA;
            ST_DATA:     return ST_ACK_DATA;
            ST_ACK_DATA: return ST_STOP;
            ST_RSTART:   return ST_DEVR;
            ST_DEVR:     return ST_ACK_DEVR;
            ST_ACK_DEVR: return ST_RDBYTE;
            ST_RDBYTE:   return ST_STOP;
            ST_STOP:     return ST_WAIT_IDLE;
            default:     return ST_IDLE;
        endcase
    endfunction

    function automatic logic [1:0] stage_of(input state_t s);
        case (s)
            ST_ACK_DEV: return 2'd1;
            ST_ACK_REG: return 2'd2;
            default:    return 2'd3;
        endcase
    endfunction

    function automatic logic is_read_step(input state_t s);
        return (s == ST_ACK_DEV) || (s == ST_ACK_REG) || (s == ST_ACK_DATA) ||
               (s == ST_ACK_DEVR) || (s == ST_RDBYTE);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= PH_REQ;
            rw_q    <= 1'b0;
            dev_q   <= '0;
            reg_q   <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            nack_q  <= 1'b0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            rw_q    <= rw_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            nack_q  <= nack_d;
            stage_q <= stage_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rw_d    = rw_q;
        dev_d   = dev_q;
        reg_d   = reg_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        nack_d  = nack_q;
        stage_d = stage_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && ready_q) begin
                    rw_d    = bus.cmd_rw;
                    dev_d   = bus.cmd_dev;
                    reg_d   = bus.cmd_reg;
                    wdata_d = bus.cmd_wdata;
                    rdata_d = '0;
                    nack_d  = 1'b0;
                    stage_d = '0;
                    state_d = ST_START;
                    phase_d = PH_REQ;
                end
            end
            ST_WAIT_IDLE: if (!bus.av_waitrequest) state_d = ST_RESP;
            ST_RESP:      state_d = ST_IDLE;
            default: begin
                case (phase_q)
                    PH_REQ: begin
                        if (!bus.av_waitrequest) begin
                            if (is_read_step(state_q))  phase_d = PH_RDWAIT;
                            else if (state_q == ST_STOP) state_d = ST_WAIT_IDLE;
                            else                         phase_d = PH_GAP;
                        end
                    end
                    PH_GAP: begin
                        state_d = step_after(state_q, rw_q);
                        phase_d = PH_REQ;
                    end
                    default: begin
                        if (bus.av_readdatavalid) begin
                            state_d = step_after(state_q, rw_q);
                            phase_d = PH_REQ;
                            if (state_q == ST_RDBYTE) begin
                                rdata_d = bus.av_readdata[7:0];
                            end else if (bus.av_readdata[1]) begin
                                if (!nack_q) begin
                                    nack_d  = 1'b1;
                                    stage_d = stage_of(state_q);
                                end
                                if (ABORT_ON_NACK) state_d = ST_STOP;
                            end
                        end
                    end
                endcase
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_comb begin
        req_write = 1'b0;
        req_read  = 1'b0;
        req_addr  = '0;
        req_byte  = '0;
        if (phase_q == PH_REQ) begin
            case (state_q)
                ST_START, ST_RSTART: begin req_write = 1'b1; req_byte = 8'h01; end
                ST_DEVW: begin req_write = 1'b1; req_addr = 2'd1; req_byte = {dev_q, 1'b0}; end
                ST_REG:  begin req_write = 1'b1; req_addr = 2'd1; req_byte = reg_q; end
                ST_DATA: begin req_write = 1'b1; req_addr = 2'd1; req_byte = wdata_q; end
                ST_DEVR: begin req_write = 1'b1; req_addr = 2'd1; req_byte = {dev_q, 1'b1}; end
                ST_STOP: req_write = 1'b1;
                ST_ACK_DEV, ST_ACK_REG, ST_ACK_DATA, ST_ACK_DEVR: req_read = 1'b1;
                ST_RDBYTE: begin req_read = 1'b1; req_addr = 2'd3; end
                default: ;
            endcase
        end
    end

    // Upper engine read bits carry nothing for this block.
    assign unused_rd_hi       = ^bus.av_readdata[31:8];

    assign bus.cmd_ready      = ready_q;
    assign bus.rsp_valid      = (state_q == ST_RESP);
    assign bus.rsp_rdata      = rdata_q;
    assign bus.rsp_nack       = nack_q;
    assign bus.rsp_nack_stage = stage_q;
    assign bus.av_write       = req_write;
    assign bus.av_read        = req_read;
    assign bus.av_address     = req_addr;
    assign bus.av_writedata   = {24'd0, req_byte};

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Table-driven bench for i2c_cmd_sequencer against a behavioural engine model,
// covering both NACK policies, engine stalls, and reset during a read.
module tb_i2c_cmd_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_cmd_sequencer_if bus_a();
    i2c_cmd_sequencer_if bus_n();

    i2c_cmd_sequencer #(.ABORT_ON_NACK(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    i2c_cmd_sequencer #(.ABORT_ON_NACK(1'b0)) u_dut_noabort (
        .clk(clk), .rst_n(rst_n), .bus(bus_n)
    );

    // Command and engine drive, shared by both instances; sel picks the active one.
    logic        sel = 1'b0;
    logic        cmd_valid = 1'b0, cmd_rw = 1'b0;
    logic [6:0]  cmd_dev = '0;
    logic [7:0]  cmd_reg = '0, cmd_wdata = '0;
    logic        waitreq = 1'b0, rdv = 1'b0;
    logic [31:0] rdata = '0;

    assign bus_a.cmd_valid = cmd_valid & ~sel;
    assign bus_n.cmd_valid = cmd_valid & sel;
    assign bus_a.cmd_rw = cmd_rw;       assign bus_n.cmd_rw = cmd_rw;
    assign bus_a.cmd_dev = cmd_dev;     assign bus_n.cmd_dev = cmd_dev;
    assign bus_a.cmd_reg = cmd_reg;     assign bus_n.cmd_reg = cmd_reg;
    assign bus_a.cmd_wdata = cmd_wdata; assign bus_n.cmd_wdata = cmd_wdata;
    assign bus_a.av_waitrequest = waitreq;  assign bus_n.av_waitrequest = waitreq;
    assign bus_a.av_readdatavalid = rdv;    assign bus_n.av_readdatavalid = rdv;
    assign bus_a.av_readdata = rdata;       assign bus_n.av_readdata = rdata;

    logic        m_write, m_read, m_ready, m_rsp;
    logic [1:0]  m_addr, m_stage;
    logic [31:0] m_wdata;
    logic [7:0]  m_rdata;
    logic        m_nack;
    assign m_write = sel ? bus_n.av_write       : bus_a.av_write;
    assign m_read  = sel ? bus_n.av_read        : bus_a.av_read;
    assign m_addr  = sel ? bus_n.av_address     : bus_a.av_address;
    assign m_wdata = sel ? bus_n.av_writedata   : bus_a.av_writedata;
    assign m_ready = sel ? bus_n.cmd_ready      : bus_a.cmd_ready;
    assign m_rsp   = sel ? bus_n.rsp_valid      : bus_a.rsp_valid;
    assign m_rdata = sel ? bus_n.rsp_rdata      : bus_a.rsp_rdata;
    assign m_nack  = sel ? bus_n.rsp_nack       : bus_a.rsp_nack;
    assign m_stage = sel ? bus_n.rsp_nack_stage : bus_a.rsp_nack_stage;

    int checks = 0;
    int errors = 0;
    int cur_idx = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h want %0h", name, cur_idx, act, exp);
        end
    endtask

    // Engine model: op code = {read, addr, data byte} as 16'h{r}{a}{dd}.
    logic [15:0] ops[$];
    bit          stress = 1'b0;
    logic [2:0]  nack_mask = '0;
    logic [7:0]  slave_byte = '0;
    int          ack_idx = 0;
    int          proto_err = 0;
    int          wcnt = 0, rdv_cnt = 0, idle_busy = 0;
    bit          pend = 0, rd_out = 0, prev_acc = 0, prev_wait = 0;
    logic [15:0] prev_op = '0;
    logic [31:0] rd_value = '0;

    always @(negedge clk) begin : engine
        logic [15:0] op;
        logic        req;
        if (!rst_n) begin
            waitreq = 1'b0; rdv = 1'b0; rdata = '0;
            pend = 0; rd_out = 0; rdv_cnt = 0; idle_busy = 0;
            prev_acc = 0; prev_wait = 0;
        end else begin
            req = m_write | m_read;
            op  = {3'b000, m_read, 2'b00, m_addr, m_wdata[7:0]};
            rdv = 1'b0;
            rdata = '0;
            if (m_write && m_read) proto_err++;
            if (m_wdata[31:8] != 24'd0) proto_err++;
            if (prev_acc && req) proto_err++;
            if (prev_wait && (!req || op != prev_op)) proto_err++;
            if (rd_out && req) proto_err++;
            if (m_ready && m_rsp) proto_err++;
            prev_acc = 0;
            prev_wait = 0;
            if (rd_out) begin
                rdv_cnt--;
                if (rdv_cnt == 0) begin
                    rd_out = 0; rdv = 1'b1; rdata = rd_value;
                end
            end else if (stress && !req && $urandom_range(0, 7) == 0) begin
                rdv = 1'b1; rdata = 32'hFFFF_FFFF;
            end
            if (req) begin
                if (!pend) begin
                    pend = 1;
                    wcnt = stress ? int'($urandom_range(0, 20)) : 0;
                end
                if (wcnt == 0) begin
                    waitreq = 1'b0;
                    pend = 0;
                    ops.push_back(op);
                    if (m_read) begin
                        rd_out = 1;
                        rdv_cnt = stress ? int'($urandom_range(1, 5)) : 1;
                        if (m_addr == 2'd3) begin
                            rd_value = {24'hC3C3C3, slave_byte};
                        end else begin
                            rd_value = 32'hA5A5_A5FD | {30'd0, nack_mask[ack_idx], 1'b0};
                            ack_idx++;
                        end
                    end else begin
                        prev_acc = 1;
                        if (op == 16'h0000) idle_busy = stress ? int'($urandom_range(0, 20)) : 2;
                    end
                end else begin
                    waitreq = 1'b1;
                    wcnt--;
                    prev_wait = 1;
                    prev_op = op;
                end
            end else if (idle_busy > 0) begin
                waitreq = 1'b1;
                idle_busy--;
            end else begin
                waitreq = 1'b0;
            end
        end
    end

    typedef struct {
        bit          noabort;
        bit          rw;
        logic [6:0]  dev;
        logic [7:0]  rg;
        logic [7:0]  wd;
        logic [2:0]  nmask;
        logic [7:0]  slave;
        logic [7:0]  e_rdata;
        bit          e_nack;
        logic [1:0]  e_stage;
        int          nops;
        logic [191:0] ops;
    } vec_t;

    function automatic vec_t mk(bit na, bit rw, logic [6:0] dev, logic [7:0] rg, logic [7:0] wd,
                                logic [2:0] nm, logic [7:0] sl, logic [7:0] er, bit en,
                                logic [1:0] es, int n, logic [191:0] o);
        vec_t v;
        v.noabort = na; v.rw = rw; v.dev = dev; v.rg = rg; v.wd = wd; v.nmask = nm;
        v.slave = sl; v.e_rdata = er; v.e_nack = en; v.e_stage = es; v.nops = n; v.ops = o;
        return v;
    endfunction

    task automatic launch(input vec_t v);
        int guard;
        sel = v.noabort; nack_mask = v.nmask; slave_byte = v.slave; ack_idx = 0;
        ops.delete();
        @(negedge clk);
        guard = 0;
        while (!m_ready && guard < 50) begin @(negedge clk); guard++; end
        chk("ready", m_ready, 1);
        cmd_valid = 1'b1; cmd_rw = v.rw; cmd_dev = v.dev; cmd_reg = v.rg; cmd_wdata = v.wd;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("ready_drop", m_ready, 0);
        chk("clr", {m_rdata, m_nack, m_stage}, 0);
        chk("start_lat", {m_write, m_read, m_addr, m_wdata}, {1'b1, 1'b0, 2'd0, 32'd1});
    endtask

    task automatic finish(input vec_t v, input int p0);
        int guard;
        logic [15:0] e;
        if (stress) begin
            repeat (2) @(negedge clk);
            cmd_valid = 1'b1; cmd_rw = ~v.rw; cmd_dev = 7'h11; cmd_reg = 8'h66;
            @(negedge clk);
            chk("busy_ready", m_ready, 0);
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        guard = 0;
        while (!m_rsp && guard < 3000) begin @(negedge clk); guard++; end
        chk("rsp_seen", m_rsp, 1);
        if (!m_rsp) return;
        chk("rdata", m_rdata, v.e_rdata);
        chk("nack", m_nack, v.e_nack);
        chk("stage", m_stage, v.e_stage);
        @(negedge clk);
        chk("rsp_pulse", {m_rsp, m_ready}, 2'b01);
        chk("hold", {m_rdata, m_nack, m_stage}, {v.e_rdata, v.e_nack, v.e_stage});
        chk("nops", ops.size(), v.nops);
        for (int i = 0; i < v.nops; i++) begin
            e = v.ops[16*(v.nops-1-i) +: 16];
            chk("op", (i < ops.size()) ? ops[i] : 16'hDEAD, e);
        end
        chk("proto", proto_err - p0, 0);
    endtask

    task automatic run_cmd(input vec_t v);
        int p0;
        p0 = proto_err;
        launch(v);
        finish(v, p0);
    endtask

    vec_t vecs[12];

    initial begin
        int guard;
        vecs[0]  = mk(0, 0, 7'h1A, 8'h05, 8'hC3, 3'b000, 8'h00, 8'h00, 0, 2'd0, 8,
                      {16'h0001, 16'h0134, 16'h1000, 16'h0105, 16'h1000, 16'h01C3, 16'h1000, 16'h0000});
        vecs[1]  = mk(0, 1, 7'h50, 8'h10, 8'hEE, 3'b000, 8'h5A, 8'h5A, 0, 2'd0, 10,
                      {16'h0001, 16'h01A0, 16'h1000, 16'h0110, 16'h1000, 16'h0001, 16'h01A1, 16'h1000, 16'h1300, 16'h0000});
        vecs[2]  = mk(0, 0, 7'h22, 8'h05, 8'hC3, 3'b001, 8'h00, 8'h00, 1, 2'd1, 4,
                      {16'h0001, 16'h0144, 16'h1000, 16'h0000});
        vecs[3]  = mk(1, 0, 7'h1A, 8'h07, 8'h55, 3'b100, 8'h00, 8'h00, 1, 2'd3, 8,
                      {16'h0001, 16'h0134, 16'h1000, 16'h0107, 16'h1000, 16'h0155, 16'h1000, 16'h0000});
        vecs[4]  = mk(0, 1, 7'h22, 8'h10, 8'h00, 3'b001, 8'h77, 8'h00, 1, 2'd1, 4,
                      {16'h0001, 16'h0144, 16'h1000, 16'h0000});
        vecs[5]  = mk(0, 0, 7'h3C, 8'h99, 8'h01, 3'b010, 8'h00, 8'h00, 1, 2'd2, 6,
                      {16'h0001, 16'h0178, 16'h1000, 16'h0199, 16'h1000, 16'h0000});
        vecs[6]  = mk(1, 1, 7'h3C, 8'h20, 8'h00, 3'b100, 8'hE7, 8'hE7, 1, 2'd3, 10,
                      {16'h0001, 16'h0178, 16'h1000, 16'h0120, 16'h1000, 16'h0001, 16'h0179, 16'h1000, 16'h1300, 16'h0000});
        vecs[7]  = mk(1, 0, 7'h1A, 8'h05, 8'hC3, 3'b011, 8'h00, 8'h00, 1, 2'd1, 8,
                      {16'h0001, 16'h0134, 16'h1000, 16'h0105, 16'h1000, 16'h01C3, 16'h1000, 16'h0000});
        vecs[8]  = mk(0, 1, 7'h7F, 8'hFF, 8'h00, 3'b000, 8'hFF, 8'hFF, 0, 2'd0, 10,
                      {16'h0001, 16'h01FE, 16'h1000, 16'h01FF, 16'h1000, 16'h0001, 16'h01FF, 16'h1000, 16'h1300, 16'h0000});
        vecs[9]  = mk(0, 0, 7'h00, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 0, 2'd0, 8,
                      {16'h0001, 16'h0100, 16'h1000, 16'h0100, 16'h1000, 16'h0100, 16'h1000, 16'h0000});
        vecs[10] = mk(0, 1, 7'h50, 8'h10, 8'h00, 3'b100, 8'h99, 8'h00, 1, 2'd3, 9,
                      {16'h0001, 16'h01A0, 16'h1000, 16'h0110, 16'h1000, 16'h0001, 16'h01A1, 16'h1000, 16'h0000});
        vecs[11] = mk(1, 1, 7'h50, 8'h10, 8'h00, 3'b000, 8'h3C, 8'h3C, 0, 2'd0, 10,
                      {16'h0001, 16'h01A0, 16'h1000, 16'h0110, 16'h1000, 16'h0001, 16'h01A1, 16'h1000, 16'h1300, 16'h0000});

        repeat (3) @(negedge clk);
        chk("reset_a", {bus_a.cmd_ready, bus_a.rsp_valid, bus_a.rsp_rdata, bus_a.rsp_nack, bus_a.rsp_nack_stage,
                        bus_a.av_write, bus_a.av_read, bus_a.av_address, bus_a.av_writedata}, 0);
        chk("reset_n", {bus_n.cmd_ready, bus_n.rsp_valid, bus_n.av_write, bus_n.av_read}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_rel", {bus_a.cmd_ready, bus_n.cmd_ready}, 2'b11);

        for (int pass = 0; pass < 2; pass++) begin
            stress = (pass == 1);
            for (int i = 0; i < 12; i++) begin
                cur_idx = pass * 100 + i;
                run_cmd(vecs[i]);
            end
        end

        // Reset asserted while the read byte is outstanding.
        stress = 1'b0;
        cur_idx = 200;
        launch(vecs[1]);
        guard = 0;
        while (!(m_read && m_addr == 2'd3) && guard < 200) begin @(negedge clk); guard++; end
        chk("rst_reach", m_read && m_addr == 2'd3, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_outs", {m_ready, m_rsp, m_write, m_read, m_addr, m_wdata, m_rdata, m_nack, m_stage}, 0);
        guard = 0;
        repeat (4) begin
            @(negedge clk);
            if (m_rsp) guard++;
        end
        chk("rst_no_rsp", guard, 0);
        rst_n = 1'b1;
        cur_idx = 201;
        run_cmd(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
